// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage divider: state encoding, handshake levels and opcodes.
package ex_div_pkg;

    typedef logic [1:0] div_state_t;

    localparam div_state_t S_FREE    = 2'd0;
    localparam div_state_t S_BY_ZERO = 2'd1;
    localparam div_state_t S_ON      = 2'd2;
    localparam div_state_t S_END     = 2'd3;

    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/ex_div_if.sv
// EX-stage <-> divider bundle; i_annul exists only when DIV_ANNUL_EN is defined.
// Handshake: EX holds i_start high with stable intent until it sees o_ready, then drops i_start for >= 1 cycle.
interface ex_div_if #(parameter int W = 32);

    logic                        i_start;
    logic                        i_signed;
    logic [W-1:0]                i_dividend;
    logic [W-1:0]                i_divisor;
`ifdef DIV_ANNUL_EN
    logic                        i_annul;
`endif
    logic                        o_busy;
    logic                        o_ready;
    logic [2*W-1:0]              o_result;
    ex_div_pkg::div_state_t      dbg_state;

    modport master (
        output i_start,
`ifdef DIV_ANNUL_EN
        output i_annul,
`endif
        output i_signed, i_dividend, i_divisor,
        input  o_busy, o_ready, o_result, dbg_state
    );

    modport slave (
        input  i_start,
`ifdef DIV_ANNUL_EN
        input  i_annul,
`endif
        input  i_signed, i_dividend, i_divisor,
        output o_busy, o_ready, o_result, dbg_state
    );

endinterface

// File: rtl/ex_div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial-remainder window.
module ex_div_step #(
    parameter int W = 32
) (
    input  logic [W+1:0] win,      // partial remainder bits [2W:W-1], i.e. the upper part after a left shift
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_nxt,
    output logic         q_bit
);

    logic [W+1:0] trial;

    assign trial   = win - {2'b00, divisor};
    assign q_bit   = ~trial[W+1];
    assign rem_nxt = q_bit ? trial[W:0] : win[W:0];

endmodule

// File: rtl/ex_div.sv
// Multi-cycle restoring integer divider (DIV/DIVU), one quotient bit per cycle.
// Optional cancel input compiled in with DIV_ANNUL_EN.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int W = 32
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    ex_div_if.slave  bus
);

    localparam int CW = $clog2(W + 1);
    localparam int PW = 2 * W + 1;

    div_state_t     state;
    div_state_t     state_nxt;
    logic [CW-1:0]  cnt;
    logic [PW-1:0]  pr;
    logic [PW-1:0]  pr_nxt;
    logic [W-1:0]   dvsr;
    logic           q_neg;
    logic           r_neg;
    logic [2*W-1:0] result;
    logic           busy;
    logic           ready;
    logic           annul;

    logic [W:0]     rem_nxt;
    logic           q_bit;
    logic           dvd_neg;
    logic           dvs_neg;
    logic [W-1:0]   dvd_mag;
    logic [W-1:0]   dvs_mag;
    logic [W-1:0]   q_fin;
    logic [W-1:0]   r_fin;
    logic [2*W-1:0] res_fin;

`ifdef DIV_ANNUL_EN
    assign annul = bus.i_annul;
`else
    assign annul = 1'b0;
`endif

    // The most negative value negates to itself, which is already its magnitude read as unsigned.
    always_comb begin
        dvd_neg = bus.i_signed & bus.i_dividend[W-1];
        dvs_neg = bus.i_signed & bus.i_divisor[W-1];
        dvd_mag = dvd_neg ? (~bus.i_dividend + 1'b1) : bus.i_dividend;
        dvs_mag = dvs_neg ? (~bus.i_divisor + 1'b1) : bus.i_divisor;
    end

    ex_div_step #(.W(W)) u_step (
        .win     (pr[2*W:W-1]),
        .divisor (dvsr),
        .rem_nxt (rem_nxt),
        .q_bit   (q_bit)
    );

    assign pr_nxt = {rem_nxt, pr[W-2:0], q_bit};

    // Sign correction is folded into the edge that enters END.
    always_comb begin
        q_fin   = pr_nxt[W-1:0];
        r_fin   = pr_nxt[2*W-1:W];
        res_fin = {r_neg ? (~r_fin + 1'b1) : r_fin,
                   q_neg ? (~q_fin + 1'b1) : q_fin};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FREE: begin
                if (bus.i_start == DIV_START && !annul)
                    state_nxt = (bus.i_divisor == '0) ? S_BY_ZERO : S_ON;
            end
            S_BY_ZERO: state_nxt = annul ? S_FREE : S_END;
            S_ON: begin
                if (annul)
                    state_nxt = S_FREE;
                else if (cnt == CW'(W - 1))
                    state_nxt = S_END;
            end
            S_END: begin
                if (bus.i_start == DIV_STOP)
                    state_nxt = S_FREE;
            end
            default: state_nxt = S_FREE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_FREE;
            cnt    <= '0;
            pr     <= '0;
            dvsr   <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            result <= '0;
            busy   <= 1'b0;
            ready  <= DIV_NOT_READY;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_ON) || (state_nxt == S_BY_ZERO);
            ready <= (state_nxt == S_END) ? DIV_READY : DIV_NOT_READY;
            case (state)
                S_FREE: begin
                    if (state_nxt == S_ON) begin
                        pr    <= {{(W + 1){1'b0}}, dvd_mag};
                        dvsr  <= dvs_mag;
                        q_neg <= dvd_neg ^ dvs_neg;
                        r_neg <= dvd_neg;
                        cnt   <= '0;
                    end
                end
                S_ON: begin
                    if (state_nxt == S_FREE) begin
                        cnt <= '0;
                    end else begin
                        pr  <= pr_nxt;
                        cnt <= cnt + CW'(1);
                        if (state_nxt == S_END)
                            result <= res_fin;
                    end
                end
                S_BY_ZERO: begin
                    if (state_nxt == S_END)
                        result <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy    = busy;
    assign bus.o_ready   = ready;
    assign bus.o_result  = result;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_ex_div.sv
// Directed-vector bench for ex_div (W=32); build with or without DIV_ANNUL_EN.
module tb_ex_div;
  import ex_div_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic         sgn;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ex_div_if #(.W(W)) bus();

  ex_div #(.W(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: issue one request and follow it through END and back to FREE
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] res, output int lat, output int busy_n,
                         output logic both, output logic hold_ok, output logic drop_ok);
    @(posedge clk); #1;
    bus.i_start    = 1'b1;
    bus.i_signed   = sgn;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    lat = 0; busy_n = 0; both = 1'b0;
    while (lat < 80) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        bus.i_dividend = $urandom;
        bus.i_divisor  = $urandom;
        bus.i_signed   = 1'($urandom_range(0, 1));
      end
      if (bus.o_busy) busy_n++;
      if (bus.o_busy && bus.o_ready) both = 1'b1;
      if (bus.o_ready) break;
    end
    res = bus.o_result;
    @(posedge clk); #1;
    hold_ok = bus.o_ready && (bus.o_result == res);
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    drop_ok = !bus.o_ready && !bus.o_busy && (bus.o_result == res);
  endtask

  logic [2*W-1:0] res;
  logic [2*W-1:0] last_res;
  int lat, busy_n;
  logic both, hold_ok, drop_ok;

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
    vecs[3]  = '{1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          2};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          2};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
    vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
    vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
    vecs[9]  = '{1'b0, 32'd3,          32'd5,          32'd0,          32'd3,          33};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          33};
    vecs[11] = '{1'b1, 32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  33};

    bus.i_start = 1'b0; bus.i_signed = 1'b0; bus.i_dividend = '0; bus.i_divisor = '0;
`ifdef DIV_ANNUL_EN
    bus.i_annul = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   {63'd0, bus.o_busy},  '0);
    check("reset_ready",  {63'd0, bus.o_ready}, '0);
    check("reset_result", bus.o_result,         '0);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({vecs[i].r, vecs[i].q});
      run_div(vecs[i].sgn, vecs[i].dvd, vecs[i].dvs, res, lat, busy_n, both, hold_ok, drop_ok);
      check($sformatf("v%0d_result", i), res, exp_q.pop_front());
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 64'((vecs[i].lat == 2) ? 1 : W));
      check($sformatf("v%0d_busy_ready_excl", i), {63'd0, both}, '0);
      check($sformatf("v%0d_hold", i), {63'd0, hold_ok}, 64'd1);
      check($sformatf("v%0d_drop", i), {63'd0, drop_ok}, 64'd1);
    end
    last_res = {vecs[11].r, vecs[11].q};

    // cancel at the 10th ON cycle
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_signed = 1'b0; bus.i_dividend = 32'd1000; bus.i_divisor = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    check("annul_pre_state", 64'(bus.dbg_state), 64'(S_ON));
`ifdef DIV_ANNUL_EN
    bus.i_annul = 1'b1;
    @(posedge clk); #1;
    check("annul_state",  64'(bus.dbg_state), 64'(S_FREE));
    check("annul_busy",   {63'd0, bus.o_busy},  '0);
    check("annul_ready",  {63'd0, bus.o_ready}, '0);
    check("annul_result", bus.o_result, last_res);
    bus.i_annul = 1'b0; bus.i_start = 1'b0;
    @(posedge clk); #1;
    check("annul_no_ready", {63'd0, bus.o_ready}, '0);
    run_div(1'b0, 32'd1000, 32'd3, res, lat, busy_n, both, hold_ok, drop_ok);
    check("after_annul_result",  res, {32'd1, 32'd333});
    check("after_annul_latency", 64'(lat), 64'd33);
    // annul while FREE blocks acceptance
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_annul = 1'b1; bus.i_dividend = 32'd9; bus.i_divisor = 32'd2;
    @(posedge clk); #1;
    check("annul_free_block", 64'(bus.dbg_state), 64'(S_FREE));
    bus.i_start = 1'b0; bus.i_annul = 1'b0;
    @(posedge clk); #1;
`else
    lat = 10;
    while (!bus.o_ready && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    check("no_annul_result",  bus.o_result, {32'd1, 32'd333});
    check("no_annul_latency", 64'(lat), 64'd33);
    bus.i_start = 1'b0;
    @(posedge clk); #1;
`endif

    // asynchronous reset in the middle of ON
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_signed = 1'b0; bus.i_dividend = 32'd100; bus.i_divisor = 32'd7;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy",   {63'd0, bus.o_busy},  '0);
    check("rst_ready",  {63'd0, bus.o_ready}, '0);
    check("rst_result", bus.o_result,         '0);
    check("rst_state",  64'(bus.dbg_state), 64'(S_FREE));
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, res, lat, busy_n, both, hold_ok, drop_ok);
    check("post_rst_result",  res, {32'd0, 32'hFFFF_FFFF});
    check("post_rst_latency", 64'(lat), 64'd33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Parametrised multi-cycle integer divider, the next-generation arithmetic unit beside the EX-stage ALU. It adds DIV/DIVU to the datapath: one quotient bit per cycle, signed or unsigned, with operand width as a parameter. Its quotient/remainder pair feeds the HI/LO write path, and its status drives the pipeline stall request. The EX stage holds `i_start` and stalls the pipeline until `o_ready` is seen.

## Interface
- `W`, 32, operand width in bits; legal range is 2 and above.
- `CW`, `$clog2(W+1)`, iteration counter width; derived, never overridden.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_start`  in  1  divide request, level; EX holds it high until it sees `o_ready`.
- `i_signed`  in  1  1 = DIV (two's-complement), 0 = DIVU.
- `i_dividend`  in  W  dividend.
- `i_divisor`  in  W  divisor.
- `i_annul`  in  1  cancel the in-flight divide (present only with `DIV_ANNUL_EN`).
- `o_busy`  out  1  high in states ON and BY_ZERO.
- `o_ready`  out  1  result valid; high only in state END.
- `o_result`  out  2W  `{remainder, quotient}`; `[2W-1:W]` goes to HI, `[W-1:0]` to LO.

## Operation
- **States:** FREE, BY_ZERO, ON, END.
- **FREE:**
  - When `i_start=1` and divisor ≠ 0: capture operands and `i_signed`, then go to ON with counter 0.
  - When `i_start=1` and divisor = 0: go to BY_ZERO.
  - Operand changes after capture are ignored.
- **Operand capture, signed mode:** store |dividend| and |divisor| as W-bit magnitudes.
  - The magnitude of the most negative value (`{1'b1,{W-1{1'b0}}}`) is the same bit pattern, read as unsigned.
  - Record `q_neg = sign(dividend) ^ sign(divisor)` and `r_neg = sign(dividend)`.
- **ON:** each cycle performs one restoring step on a 2W+1-bit partial remainder register.
  - Subtract the divisor from the upper W+1 bits.
  - If the result is non-negative, keep it and shift in 1; otherwise shift in 0.
  - The counter increments each cycle; when it reaches W-1, the next edge goes to END.
- **END:**
  - Apply sign correction once, on entry: negate the quotient if `q_neg`, negate the remainder if `r_neg`.
  - Hold `o_result` and `o_ready=1` while `i_start=1`.
  - `i_start=0` returns to FREE. `o_result` keeps its value until the next END.
- **BY_ZERO:** the next edge goes to END with `o_result=0`.
- **Width rules:** all results are truncated to W bits.
  - Signed most-negative ÷ −1 wraps to quotient = most-negative, remainder = 0. No overflow flag.
- **Reset (any state, including mid-ON):** state = FREE, counter = 0, `o_result=0`, `o_ready=0`, `o_busy=0`.

## Timing
- Request sampled at edge k; ON occupies edges k+1 … k+W. `o_ready` first goes high after edge k+W+1.
  - W=32: 33 cycles from request to result.
- Divide by zero: `o_ready` is high after edge k+2.
- Minimum back-to-back spacing: one FREE cycle between requests. `i_start` must drop for at least one cycle after `o_ready`.
- `i_start` falling while in ON or BY_ZERO has no effect unless annul is compiled in.
- `o_busy` and `o_ready` are registered state decodes, never both high.

## Configuration
- **`DIV_ANNUL_EN` defined:**
  - `i_annul` port exists. `i_annul=1` in ON or BY_ZERO returns to FREE on the next edge, with `o_ready` never asserted and `o_result` unchanged.
  - `i_annul=1` in FREE blocks acceptance that cycle.
  - `i_annul` in END is ignored.
- **Not defined:** port absent; every accepted divide runs to END.

## Structure
- **Shared defines package** holds:
  - the state typedef (`div_state_t`: FREE/BY_ZERO/ON/END);
  - `DIV_START`/`DIV_STOP` and `DIV_READY`/`DIV_NOT_READY` constants;
  - `EXE_DIV_OP`/`EXE_DIVU_OP` opcodes.
- **One sub-module, `ex_div_step`:** combinational W+1-bit trial subtract. Takes the partial remainder and the divisor; returns the next partial remainder and the quotient bit.

## Test plan
- **DIVU 100 / 7, W=32:** q=14, r=2; `o_ready` first high exactly 33 cycles after the request.
- **DIV −7 / 2:** q=0xFFFFFFFD, r=0xFFFFFFFF. **DIV 7 / −2:** q=0xFFFFFFFD, r=1.
- **DIV or DIVU 5 / 0:** `o_result=0`; `o_ready` high 2 cycles after the request; `o_busy` high for 1 cycle.
- **DIV 0x80000000 / 0xFFFFFFFF:** q=0x80000000, r=0. **DIVU same operands:** q=0, r=0x80000000.
- **Mid-operation cancel:** with `DIV_ANNUL_EN`, `i_annul` at cycle 10 of ON → FREE next edge, no `o_ready`, and the next request is then accepted normally. Without the macro, the same stimulus completes normally.
- **Reset mid-operation:** drop `i_rst_n` mid-ON → all outputs 0 immediately (asynchronously); after release, DIVU 0xFFFFFFFF / 1 gives q=0xFFFFFFFF, r=0.
